ucie_ctl_sb_tx_arbiter: RTL and testbench

// - Schedules the single PHY sideband TX channel between two requesters: link-management

---
 rtl/ucie_ctl_sb_tx_arbiter.sv | 124 ++++++++++++
 tb/tb_ucie_ctl_sb_tx_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Sideband TX arbiter: shares one serializer channel between link-management messages
// and RDI config words, with a credit-managed config FIFO and a message starvation guard.
module ucie_ctl_sb_tx_arbiter #(
    parameter int NC            = 32,
    parameter int CFG_DEPTH     = 4,
    parameter int MAX_MSG_BURST = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_msg_valid,
    input  logic [3:0]    i_msg,
    output logic          o_msg_ready,
    input  logic          i_rdi_lp_cfg_valid,
    input  logic [NC-1:0] i_rdi_lp_cfg,
    output logic          o_rdi_pl_cfg_crd,
    output logic          o_sb_data_valid,
    output logic [NC-1:0] o_sb_data,
    output logic          o_sb_is_msg,
    input  logic          i_sb_ready,
    output logic          o_cfg_overflow
);

    localparam int AW = $clog2(CFG_DEPTH);
    localparam int BW = $clog2(MAX_MSG_BURST + 1);
    localparam int CW = $clog2(CFG_DEPTH) + 2;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_MSG_BURST);
    localparam logic [CW-1:0] CRD_INIT  = CW'(CFG_DEPTH);

    logic [NC-1:0] fifo_mem [CFG_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          msg_full;
    logic [3:0]    msg_code;
    logic [BW-1:0] burst_cnt;
    logic [CW-1:0] crd_pend;

    logic fifo_empty;
    logic fifo_full;
    logic load_ok;
    logic msg_load;
    logic cfg_load;
    logic cfg_push;
    logic cfg_drop;
    logic msg_accept;
    logic msg_full_next;
    logic crd_pulse;

    // Load decision: messages win unless they have hogged the channel while config waits.
    always_comb begin
        fifo_empty    = (wr_ptr == rd_ptr);
        fifo_full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        load_ok       = !o_sb_data_valid || i_sb_ready;
        msg_load      = load_ok && msg_full && ((burst_cnt < BURST_MAX) || fifo_empty);
        cfg_load      = load_ok && !msg_load && !fifo_empty;
        cfg_push      = i_rdi_lp_cfg_valid && (!fifo_full || cfg_load);
        cfg_drop      = i_rdi_lp_cfg_valid && fifo_full && !cfg_load;
        msg_accept    = i_msg_valid && o_msg_ready && (i_msg != 4'd0) && (i_msg <= 4'd8);
        msg_full_next = msg_accept || (msg_full && !msg_load);
        crd_pulse     = (crd_pend != '0) || cfg_load;
    end

    // Storage is flushed by the pointers, so the array itself needs no reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && cfg_push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= i_rdi_lp_cfg;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            msg_full         <= 1'b0;
            msg_code         <= 4'd0;
            burst_cnt        <= '0;
            crd_pend         <= CRD_INIT;
            o_msg_ready      <= 1'b0;
            o_rdi_pl_cfg_crd <= 1'b0;
            o_sb_data_valid  <= 1'b0;
            o_sb_data        <= '0;
            o_sb_is_msg      <= 1'b0;
            o_cfg_overflow   <= 1'b0;
        end else begin
            if (cfg_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (cfg_load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (cfg_drop) begin
                o_cfg_overflow <= 1'b1;
            end

            msg_full    <= msg_full_next;
            o_msg_ready <= !msg_full_next;
            if (msg_accept) begin
                msg_code <= i_msg;
            end

            if (msg_load) begin
                o_sb_data_valid <= 1'b1;
                o_sb_data       <= {{(NC-4){1'b0}}, msg_code};
                o_sb_is_msg     <= 1'b1;
            end else if (cfg_load) begin
                o_sb_data_valid <= 1'b1;
                o_sb_data       <= fifo_mem[rd_ptr[AW-1:0]];
                o_sb_is_msg     <= 1'b0;
            end else if (i_sb_ready) begin
                o_sb_data_valid <= 1'b0;
            end

            if (fifo_empty || cfg_load) begin
                burst_cnt <= '0;
            end else if (msg_load && (burst_cnt < BURST_MAX)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end

            // Init credits and pop credits share one counter so none is lost when they overlap.
            o_rdi_pl_cfg_crd <= crd_pulse;
            crd_pend         <= crd_pend + CW'(cfg_load) - CW'(crd_pulse);
        end
    end

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Bench for the sideband TX arbiter: directed scenarios plus random traffic, all checked
// against a queue-based reference model through a transfer scoreboard.
module tb_ucie_ctl_sb_tx_arbiter;

    localparam int DEPTH = 4;
    localparam int MAXB  = 3;

    typedef struct packed {
        logic        is_msg;
        logic [31:0] data;
    } word_t;

    typedef struct {
        logic        is_msg;
        logic [31:0] data;
        time         t;
    } sent_t;

    logic        clk;
    logic        rst;
    logic        msg_valid;
    logic [3:0]  msg;
    logic        msg_ready;
    logic        cfg_valid;
    logic [31:0] cfg;
    logic        cfg_crd;
    logic        sb_valid;
    logic [31:0] sb_data;
    logic        sb_is_msg;
    logic        sb_ready;
    logic        cfg_ovf;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int crd_seen    = 0;

    word_t       exp_q[$];
    sent_t       sent_log[$];
    logic [31:0] m_cfg_q[$];
    bit          m_live      = 0;
    bit          m_msg_pend  = 0;
    logic [3:0]  m_msg_code  = 0;
    bit          m_msg_ready = 0;
    bit          m_out_valid = 0;
    int          m_burst     = 0;
    int          m_crd_pend  = 0;
    bit          m_crd       = 0;
    bit          m_ovf       = 0;

    ucie_ctl_sb_tx_arbiter #(.NC(32), .CFG_DEPTH(DEPTH), .MAX_MSG_BURST(MAXB)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_msg_valid        (msg_valid),
        .i_msg              (msg),
        .o_msg_ready        (msg_ready),
        .i_rdi_lp_cfg_valid (cfg_valid),
        .i_rdi_lp_cfg       (cfg),
        .o_rdi_pl_cfg_crd   (cfg_crd),
        .o_sb_data_valid    (sb_valid),
        .o_sb_data          (sb_data),
        .o_sb_is_msg        (sb_is_msg),
        .i_sb_ready         (sb_ready),
        .o_cfg_overflow     (cfg_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic mv, input logic [3:0] mc, input logic cv,
                                 input logic [31:0] cd, input logic sr);
        msg_valid = mv;
        msg       = mc;
        cfg_valid = cv;
        cfg       = cd;
        sb_ready  = sr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference model: evaluates the scheduling rules on each edge using the inputs of the
    // cycle that just ended, and queues every word it expects to be sent.
    initial begin
        bit load_ok, fifo_empty, pick_msg, pop, accept;
        word_t w;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_live      = 1;
                m_cfg_q.delete();
                exp_q.delete();
                m_msg_pend  = 0;
                m_msg_ready = 0;
                m_out_valid = 0;
                m_burst     = 0;
                m_crd_pend  = DEPTH;
                m_crd       = 0;
                m_ovf       = 0;
            end else if (m_live) begin
                load_ok    = !m_out_valid || sb_ready;
                fifo_empty = (m_cfg_q.size() == 0);
                pick_msg   = load_ok && m_msg_pend && ((m_burst < MAXB) || fifo_empty);
                pop        = load_ok && !pick_msg && !fifo_empty;
                accept     = msg_valid && m_msg_ready && (msg >= 4'd1) && (msg <= 4'd8);

                if (pick_msg) begin
                    w.is_msg = 1'b1;
                    w.data   = {28'd0, m_msg_code};
                    exp_q.push_back(w);
                    m_out_valid = 1;
                end else if (pop) begin
                    w.is_msg = 1'b0;
                    w.data   = m_cfg_q.pop_front();
                    exp_q.push_back(w);
                    m_out_valid = 1;
                end else if (sb_ready) begin
                    m_out_valid = 0;
                end

                if (cfg_valid) begin
                    if (m_cfg_q.size() < DEPTH) m_cfg_q.push_back(cfg);
                    else m_ovf = 1;
                end

                if (fifo_empty || pop) m_burst = 0;
                else if (pick_msg && m_burst < MAXB) m_burst++;

                m_crd      = (m_crd_pend > 0) || pop;
                m_crd_pend = m_crd_pend + int'(pop) - int'(m_crd);

                if (pick_msg) m_msg_pend = 0;
                if (accept) begin
                    m_msg_pend = 1;
                    m_msg_code = msg;
                end
                m_msg_ready = !m_msg_pend;
            end
        end
    end

    // Monitor: compares per-cycle status against the model and scores each transfer.
    initial begin
        word_t w;
        sent_t s;
        forever begin
            @(negedge clk);
            if (m_live) begin
                checkOutput("sb_valid",  sb_valid,  m_out_valid);
                checkOutput("msg_ready", msg_ready, m_msg_ready);
                checkOutput("cfg_crd",   cfg_crd,   m_crd);
                checkOutput("overflow",  cfg_ovf,   m_ovf);
                if (cfg_crd === 1'b1) crd_seen++;
                if (sb_valid === 1'b1 && sb_ready === 1'b1) begin
                    s.is_msg = sb_is_msg;
                    s.data   = sb_data;
                    s.t      = $time;
                    sent_log.push_back(s);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("[TB] FAIL unexpected_word: got %0h, expected no transfer (cycle %0d)", sb_data, cyc);
                    end else begin
                        w = exp_q.pop_front();
                        checkOutput("sb_data",   sb_data,   w.data);
                        checkOutput("sb_is_msg", sb_is_msg, w.is_msg);
                    end
                end
            end
        end
    end

    initial begin
        int crd0;
        bit [7:0] pat;
        rst = 1'b1;
        applyStimulus(0, 4'd0, 0, 32'd0, 0);
        repeat (3) tick();
        rst = 1'b0;
        cyc = 0;

        // Reset release and credit init.
        checkOutput("rel_ready", msg_ready, 0);
        checkOutput("rel_crd", cfg_crd, 0);
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("init_crd", cfg_crd, (k <= 4));
            checkOutput("init_valid", sb_valid, 0);
            checkOutput("init_ready", msg_ready, 1);
        end

        // ACT_REQ at cycle 10.
        repeat (2) tick();
        applyStimulus(1, 4'd1, 0, 32'd0, 1);
        tick();
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        checkOutput("act_ready_c11", msg_ready, 0);
        checkOutput("act_valid_c11", sb_valid, 0);
        tick();
        checkOutput("act_ready_c12", msg_ready, 1);
        checkOutput("act_valid_c12", sb_valid, 1);
        checkOutput("act_data_c12", sb_data, 32'h1);
        checkOutput("act_ismsg_c12", sb_is_msg, 1);
        tick();
        checkOutput("act_valid_c13", sb_valid, 0);

        // Four back-to-back config words.
        crd0 = crd_seen;
        sent_log.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 4'd0, 1, 32'hA0 + i, 1);
            tick();
        end
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        repeat (6) tick();
        checkOutput("cfg4_count", sent_log.size(), 4);
        if (sent_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput("cfg4_data", sent_log[i].data, 32'hA0 + i);
                checkOutput("cfg4_ismsg", sent_log[i].is_msg, 0);
                checkOutput("cfg4_b2b", sent_log[i].t - sent_log[0].t, 64'(i * 10));
            end
        end
        checkOutput("cfg4_credits", crd_seen - crd0, 4);

        // Fill the FIFO behind a stalled serializer, then overflow it.
        sent_log.delete();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 4'd0, 1, 32'hB0 + i, 0);
            tick();
        end
        checkOutput("ovf_before", cfg_ovf, 0);
        applyStimulus(0, 4'd0, 1, 32'hB5, 0);
        tick();
        applyStimulus(0, 4'd0, 0, 32'd0, 0);
        checkOutput("ovf_after", cfg_ovf, 1);
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        repeat (10) tick();
        checkOutput("ovf_count", sent_log.size(), 5);
        if (sent_log.size() == 5) begin
            for (int i = 0; i < 5; i++) checkOutput("ovf_data", sent_log[i].data, 32'hB0 + i);
        end

        // Starvation guard: continuous messages with two config words waiting.
        sent_log.delete();
        for (int j = 0; j < 36; j++) begin
            applyStimulus(1, 4'd3, (j < 2), 32'hC0 + j, (j >= 4) && (j % 4 == 0));
            tick();
        end
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        repeat (10) tick();
        pat = 8'b1110_1110;
        checkOutput("burst_len", (sent_log.size() >= 8), 1);
        if (sent_log.size() >= 8) begin
            for (int i = 0; i < 8; i++) checkOutput("burst_order", sent_log[i].is_msg, pat[7-i]);
        end

        // Five-cycle stall keeps the word stable and releases it once.
        sent_log.delete();
        applyStimulus(0, 4'd0, 1, 32'hD0, 0);
        tick();
        applyStimulus(0, 4'd0, 0, 32'd0, 0);
        tick();
        for (int s = 0; s < 5; s++) begin
            checkOutput("stall_valid", sb_valid, 1);
            checkOutput("stall_data", sb_data, 32'hD0);
            tick();
        end
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        tick();
        checkOutput("stall_released", sb_valid, 0);
        checkOutput("stall_count", sent_log.size(), 1);
        if (sent_log.size() == 1) checkOutput("stall_word", sent_log[0].data, 32'hD0);

        // Reset with a message and two config words queued.
        applyStimulus(0, 4'd0, 1, 32'hE0, 0);
        tick();
        applyStimulus(1, 4'd4, 1, 32'hE1, 0);
        tick();
        applyStimulus(0, 4'd0, 1, 32'hE2, 0);
        tick();
        applyStimulus(0, 4'd0, 0, 32'd0, 0);
        repeat (2) tick();
        checkOutput("pre_rst_ovf", cfg_ovf, 1);
        sent_log.delete();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        cyc = 0;
        checkOutput("rst2_ovf", cfg_ovf, 0);
        checkOutput("rst2_valid", sb_valid, 0);
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput("rst2_crd", cfg_crd, (k <= 4));
        end
        repeat (5) tick();
        checkOutput("rst2_no_tx", sent_log.size(), 0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                          $urandom_range(0, 9) < 3, $urandom, $urandom_range(0, 3) != 0);
            tick();
        end
        rst = 1'b0;
        applyStimulus(0, 4'd0, 0, 32'd0, 1);
        repeat (20) tick();
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
